alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 8-bit combinational ALU.
- Operand width is set by a parameter. Accepts one operation per handshake and returns a registered result plus status flags.
- Adds multi-cycle iterative multiply, shifts, an internal result accumulator used by NOT C, and illegal-opcode reporting.
- Sits between the instruction decoder (op/operand source) and the register-file writeback stage.

Parameters:
- W, 8, operand/result width in bits; legal range 4..32.
- SHW, $clog2(W), width of the shift-amount field taken from the low bits of B/Lit.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- op  in  5  opcode; bit4=1 selects lit in place of b.
- a  in  W  operand A.
- b  in  W  operand B.
- lit  in  W  literal operand.
- out_valid  out  1  result/flags valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- result  out  W  operation result; also the internal accumulator C.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[W-1].
- flag_c  out  1  carry, borrow or multiply overflow.
- flag_v  out  1  signed overflow (add/sub only, else 0).
- err  out  1  illegal opcode for the current result; valid with out_valid.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; result=0; all flags=0; err=0; out_valid=0; in_ready=1.
- Reset mid-operation aborts the operation and discards any pending output.
- Operand select: X=a. Y=b when op[4]=0, Y=lit when op[4]=1. Operands are latched at accept.
- Accept condition: in_valid && in_ready.
- Opcodes, low nibble, with op[4] selecting b or lit:
  - 1 ADD: X+Y; c=carry-out; v=signed overflow.
  - 2 SUB: X-Y; c=borrow (X<Y unsigned); v=signed overflow.
  - 3 MUL: low W bits of X*Y; c=1 if upper W bits are nonzero.
  - 5 AND, 6 OR, 7 XOR: bitwise.
  - 9 SHL: X << Y[SHW-1:0].
  - A SHR: logical X >> Y[SHW-1:0].
  - 04 NOT A and 08 NOT C exist only with op[4]=0. NOT C is ~result, using the accumulator value from before this operation.
  - All other codes are illegal, including 0x00, 0x14, 0x18 and 0x0B/0x0C when ALU_DIV_EN is not defined.
- FSM:
  - IDLE: on accept, a single-cycle op goes to DONE with result registered (latency 1; out_valid rises the cycle after accept). MUL goes to MUL.
  - MUL: shift-add, one bit per cycle, exactly W cycles, then DONE. MUL latency is W+1 cycles from accept to out_valid.
  - DONE: out_valid=1. result, flags and err are stable while out_valid && !out_ready. On out_ready, go to IDLE.
  - in_ready=0 outside IDLE, so there is no new accept in the out_ready cycle; throughput is 1 per 2 cycles for single-cycle ops.
- Illegal opcode: result keeps its previous value; flags hold their previous values; err=1; normal DONE handshake.
- Flags z and n are recomputed for every legal op. c=0 and v=0 for logic, shift and NOT ops.
- All arithmetic wraps modulo 2^W; no saturation.
- Simultaneous in_valid while busy: ignored, with in_ready=0; the producer must hold the request.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined:
  - Opcode 0B (DIV, X/Y unsigned) and 0C (REM, X%Y) are legal with either operand source; 1B/1C use lit.
  - Restoring division runs in a DIV state for W cycles; latency W+1.
  - Divide by zero: result = all ones for DIV, X for REM; c=1, err=0.
- Not defined: 0B/0C/1B/1C are illegal (err=1), no divider logic is present, and timing of all other ops is unchanged.

Test Plan:
- Reset then ADD: W=8, op=01, a=0xF0, b=0x20 -> out_valid 1 cycle after accept; result=0x10, c=1, v=0, z=0, err=0.
- Signed overflow with literal: op=11, a=0x7F, lit=0x01 -> result=0x80, v=1, n=1, c=0.
- Multicycle MUL with backpressure: op=03, a=0x12, b=0x10 -> out_valid exactly 9 cycles after accept; result=0x20, c=1. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, extra in_valid ignored.
- NOT C chain: SUB a=0x05, b=0x05 gives result=0x00, z=1. Then op=08 gives result=0xFF, n=1, z=0.
- Illegal op 0x14 after result=0x3C -> err=1, result stays 0x3C; next legal op clears err.
- Reset mid-MUL: assert rst at cycle 3 of MUL -> next cycle state=IDLE, out_valid=0, result=0x00, in_ready=1. With ALU_DIV_EN defined, op=0B, a=0x64, b=0x00 -> result=0xFF, c=1, err=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked W-bit ALU with accumulator, iterative MUL and optional DIV/REM (ALU_DIV_EN).
// Latency 1 cycle (W+1 for MUL/DIV); result held in DONE until out_ready; in_ready only in IDLE.
module alu_seq #(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] lit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_c,
  output logic         flag_v,
  output logic         err
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef ALU_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
`endif

  logic [1:0]    state;
  logic [W-1:0]  x_q;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [CW-1:0] cnt;

  logic [W-1:0]  y_sel;
  logic [W:0]    sum;
  logic [W:0]    diff;
  logic          legal;
  logic          is_mul;
  logic [W-1:0]  alu_res;
  logic          alu_c;
  logic          alu_v;

  logic [W:0]    mul_sum;
  logic [W-1:0]  it_res;
  logic          it_c;

`ifdef ALU_DIV_EN
  logic [W-1:0]  y_q;
  logic          rem_q;
  logic          is_div;
  logic [W:0]    div_sh;
  logic          div_ge;
  logic [W-1:0]  div_sub;
  logic [W-1:0]  div_r;
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_comb begin
    y_sel   = op[4] ? lit : b;
    sum     = {1'b0, a} + {1'b0, y_sel};
    diff    = {1'b0, a} - {1'b0, y_sel};
    legal   = 1'b1;
    is_mul  = 1'b0;
    alu_res = result;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
`ifdef ALU_DIV_EN
    is_div  = 1'b0;
`endif
    case (op[3:0])
      4'h1: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (a[W-1] == y_sel[W-1]) && (sum[W-1] != a[W-1]);
      end
      4'h2: begin
        alu_res = diff[W-1:0];
        alu_c   = diff[W];
        alu_v   = (a[W-1] != y_sel[W-1]) && (diff[W-1] != a[W-1]);
      end
      4'h3: is_mul = 1'b1;
      4'h4: begin
        alu_res = ~a;
        legal   = ~op[4];
      end
      4'h5: alu_res = a & y_sel;
      4'h6: alu_res = a | y_sel;
      4'h7: alu_res = a ^ y_sel;
      // NOT C reads the accumulator as it stood before this operation
      4'h8: begin
        alu_res = ~result;
        legal   = ~op[4];
      end
      4'h9: alu_res = a << y_sel[SHW-1:0];
      4'hA: alu_res = a >> y_sel[SHW-1:0];
`ifdef ALU_DIV_EN
      4'hB, 4'hC: is_div = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end

  // Shift-add: {hi,lo} starts as {0,Y}; after W steps it holds the full 2W-bit product
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, x_q} : {(W+1){1'b0}});
    it_res  = {mul_sum[0], lo[W-1:1]};
    it_c    = |mul_sum[W:1];
`ifdef ALU_DIV_EN
    div_sh  = {hi, lo[W-1]};
    div_ge  = (div_sh >= {1'b0, y_q});
    div_sub = div_sh[W-1:0] - y_q;
    div_r   = div_ge ? div_sub : div_sh[W-1:0];
    if (state == S_DIV) begin
      it_res = rem_q ? div_r : {lo[W-2:0], div_ge};
      it_c   = (y_q == '0);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      result <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      err    <= 1'b0;
      x_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
`ifdef ALU_DIV_EN
      y_q    <= '0;
      rem_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_q <= a;
            cnt <= '0;
            hi  <= '0;
            if (!legal) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else if (is_mul) begin
              lo    <= y_sel;
              err   <= 1'b0;
              state <= S_MUL;
`ifdef ALU_DIV_EN
            end else if (is_div) begin
              lo    <= a;
              y_q   <= y_sel;
              rem_q <= op[2];
              err   <= 1'b0;
              state <= S_DIV;
`endif
            end else begin
              result <= alu_res;
              flag_z <= (alu_res == '0);
              flag_n <= alu_res[W-1];
              flag_c <= alu_c;
              flag_v <= alu_v;
              err    <= 1'b0;
              state  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          hi  <= mul_sum[W:1];
          lo  <= it_res;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            result <= it_res;
            flag_z <= (it_res == '0);
            flag_n <= it_res[W-1];
            flag_c <= it_c;
            flag_v <= 1'b0;
            state  <= S_DONE;
          end
        end
`ifdef ALU_DIV_EN
        // Restoring division: remainder in hi, dividend shifts out of lo as quotient shifts in
        S_DIV: begin
          hi  <= div_r;
          lo  <= {lo[W-2:0], div_ge};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            result <= it_res;
            flag_z <= (it_res == '0);
            flag_n <= it_res[W-1];
            flag_c <= it_c;
            flag_v <= 1'b0;
            state  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (W=8): reference model pushes expected records at issue,
// each test pops and compares when the DUT presents out_valid.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] lit;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         err;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    logic       e;
  } rec_t;

  rec_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic [7:0] m_res;
  logic m_z, m_n, m_c, m_v;

  alu_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .lit(lit), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t obs();
    return {result, flag_z, flag_n, flag_c, flag_v, err};
  endfunction

  task automatic model_reset();
    m_res = 8'h00; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    q.delete();
  endtask

  // Reference model: plain integer arithmetic, updates accumulator and pushes expectation
  task automatic push_model(input logic [4:0] o, input logic [7:0] xa, input logic [7:0] xb,
                            input logic [7:0] xl);
    logic [7:0] x, y, res;
    logic c, v, legal;
    logic [15:0] p;
    int t, sx, sy;
    x = xa; y = o[4] ? xl : xb;
    sx = int'($signed(x)); sy = int'($signed(y));
    res = m_res; c = 1'b0; v = 1'b0; legal = 1'b1;
    case (o)
      5'h01, 5'h11: begin
        t = int'(x) + int'(y); res = t[7:0]; c = (t > 255);
        t = sx + sy; v = (t > 127) || (t < -128);
      end
      5'h02, 5'h12: begin
        t = int'(x) - int'(y); res = t[7:0]; c = (x < y);
        t = sx - sy; v = (t > 127) || (t < -128);
      end
      5'h03, 5'h13: begin
        p = 16'(x) * 16'(y); res = p[7:0]; c = (p[15:8] != 8'h00);
      end
      5'h04: res = ~x;
      5'h05, 5'h15: res = x & y;
      5'h06, 5'h16: res = x | y;
      5'h07, 5'h17: res = x ^ y;
      5'h08: res = ~m_res;
      5'h09, 5'h19: res = x << y[2:0];
      5'h0A, 5'h1A: res = x >> y[2:0];
`ifdef ALU_DIV_EN
      5'h0B, 5'h1B: begin res = (y == 8'h00) ? 8'hFF : x / y; c = (y == 8'h00); end
      5'h0C, 5'h1C: begin res = (y == 8'h00) ? x : x % y; c = (y == 8'h00); end
`endif
      default: legal = 1'b0;
    endcase
    if (legal) begin
      m_res = res; m_z = (res == 8'h00); m_n = res[7]; m_c = c; m_v = v;
      q.push_back({res, m_z, m_n, c, v, 1'b0});
    end else begin
      q.push_back({m_res, m_z, m_n, m_c, m_v, 1'b1});
    end
  endtask

  task automatic issue(input logic [4:0] o, input logic [7:0] xa, input logic [7:0] xb,
                       input logic [7:0] xl);
    int n;
    n = 0;
    @(negedge clk);
    op = o; a = xa; b = xb; lit = xl; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    push_model(o, xa, xb, xl);
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic collect(output rec_t got, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    got = obs();
    lat = out_valid ? (cyc - acc_cyc + 1) : -1;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 5'h00; a = 8'h00; b = 8'h00; lit = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++;
    if ({out_valid, in_ready, obs()} !== {1'b0, 1'b1, 8'h00, 5'b00000}) begin
      bad++;
      $display("FAIL reset: got vld/rdy/out=%b/%b/%h want 0/1/%h", out_valid, in_ready, obs(), 13'h0);
    end
  endtask

  task automatic test_add();
    rec_t got, exp;
    int lat;
    issue(5'h01, 8'hF0, 8'h20, 8'h00);
    collect(got, lat);
    exp = q.pop_front();
    total++;
    if (lat !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", lat); end
    total++;
    if (got !== exp) begin bad++; $display("FAIL add_result: got %h want %h", got, exp); end
    ack();
  endtask

  task automatic test_lit_overflow();
    rec_t got, exp;
    int lat;
    issue(5'h11, 8'h7F, 8'h55, 8'h01);
    collect(got, lat);
    exp = q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL lit_overflow: got %h want %h", got, exp); end
    total++;
    if (lat !== 1) begin bad++; $display("FAIL lit_latency: got %0d want 1", lat); end
    ack();
  endtask

  task automatic test_mul_backpressure();
    rec_t got, exp;
    int lat;
    issue(5'h03, 8'h12, 8'h10, 8'h00);
    collect(got, lat);
    exp = q.pop_front();
    total++;
    if (lat !== 9) begin bad++; $display("FAIL mul_latency: got %0d want 9", lat); end
    total++;
    if (got !== exp) begin bad++; $display("FAIL mul_result: got %h want %h", got, exp); end
    op = 5'h01; a = 8'h01; b = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, obs()} !== {1'b1, 1'b0, got}) begin
        bad++;
        $display("FAIL mul_stall%0d: got %b/%b/%h want 1/0/%h", i, out_valid, in_ready, obs(), got);
      end
    end
    in_valid = 1'b0;
    ack();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL mul_release: got vld/rdy %b/%b want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mul_extra_req: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_not_chain();
    rec_t got, exp;
    int lat;
    issue(5'h02, 8'h05, 8'h05, 8'h00);
    collect(got, lat);
    exp = q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL sub_zero: got %h want %h", got, exp); end
    ack();
    issue(5'h08, 8'h00, 8'h00, 8'h00);
    collect(got, lat);
    exp = q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL not_c: got %h want %h", got, exp); end
    ack();
  endtask

  task automatic test_illegal();
    rec_t got, exp;
    int lat;
    logic [4:0] ops [5] = '{5'h01, 5'h14, 5'h00, 5'h18, 5'h05};
    logic [7:0] as  [5] = '{8'h30, 8'hAA, 8'h11, 8'h22, 8'h0F};
    logic [7:0] bs  [5] = '{8'h0C, 8'h55, 8'h33, 8'h44, 8'hF3};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], 8'h99);
      collect(got, lat);
      exp = q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL illegal_seq%0d op=%h: got %h want %h", i, ops[i], got, exp); end
      ack();
    end
  endtask

  task automatic test_back_to_back();
    rec_t got, exp;
    int lat;
    logic [4:0] tbl [22] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                             5'h0A, 5'h11, 5'h12, 5'h13, 5'h15, 5'h19, 5'h1A, 5'h14, 5'h18,
                             5'h00, 5'h0B, 5'h1C, 5'h0F};
    logic [4:0] o;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      o = tbl[$urandom_range(21, 0)];
      issue(o, 8'($urandom), 8'($urandom), 8'($urandom));
      collect(got, lat);
      exp = q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL b2b%0d op=%h: got %h want %h", i, o, got, exp); end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    rec_t got, exp;
    int lat;
    issue(5'h03, 8'h12, 8'h10, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++;
    if ({out_valid, in_ready, result, err} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_mul: got vld/rdy/res/err %b/%b/%h/%b want 0/1/00/0", out_valid, in_ready, result, err);
    end
    repeat (12) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mul_discard: out_valid got %b want 0", out_valid); end
    issue(5'h0B, 8'h64, 8'h00, 8'h00);
    collect(got, lat);
    exp = q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL div_by_zero: got %h want %h", got, exp); end
    ack();
    issue(5'h1C, 8'h64, 8'h00, 8'h07);
    collect(got, lat);
    exp = q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL rem_lit: got %h want %h", got, exp); end
    ack();
  endtask

  initial begin
    test_reset();
    test_add();
    test_lit_overflow();
    test_mul_backpressure();
    test_not_chain();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
